// File: rtl/timer_bcd_core_if.sv
// timer_bcd_core_if: control, preset and BCD digit bundle of the MM:SS timer core
interface timer_bcd_core_if;
    logic        i_start, i_stop, i_clear, i_load, i_dir, i_blank_lz;
    logic [15:0] i_preset;
    logic [3:0]  o_dig3, o_dig2, o_dig1, o_dig0;
    logic        o_run, o_done, o_tick;
    modport master (
        output i_start, i_stop, i_clear, i_load, i_dir, i_blank_lz, i_preset,
        input  o_dig3, o_dig2, o_dig1, o_dig0, o_run, o_done, o_tick
    );
    modport slave (
        input  i_start, i_stop, i_clear, i_load, i_dir, i_blank_lz, i_preset,
        output o_dig3, o_dig2, o_dig1, o_dig0, o_run, o_done, o_tick
    );
endinterface

// File: rtl/timer_bcd_core.sv
// timer_bcd_core: 1 Hz up/down MM:SS BCD timer with preset, pause and leading-zero blanking
module timer_bcd_core #(
    parameter int TICK_DIV = 50_000_000
) (
    input logic              i_clk,
    input logic              i_rst,
    timer_bcd_core_if.slave  bus
);
    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
    state_t        state;
    logic [PW-1:0] presc;
    logic [15:0]   value, inc, dec, nxt, clamp;
    logic [3:0]    m1, m0, s1, s0;
    logic          dir, done_q, tick, terminal, at_end;
    assign {m1, m0, s1, s0} = value;
    assign tick = (state == RUN) && (presc == PW'(TICK_DIV - 1));
    always_comb begin
        inc[3:0]   = (s0 == 4'd9) ? 4'd0 : s0 + 4'd1;
        inc[7:4]   = (s0 != 4'd9) ? s1 : (s1 == 4'd5) ? 4'd0 : s1 + 4'd1;
        inc[11:8]  = !(s0 == 4'd9 && s1 == 4'd5) ? m0 : (m0 == 4'd9) ? 4'd0 : m0 + 4'd1;
        inc[15:12] = !(s0 == 4'd9 && s1 == 4'd5 && m0 == 4'd9) ? m1 : m1 + 4'd1;
        dec[3:0]   = (s0 == 4'd0) ? 4'd9 : s0 - 4'd1;
        dec[7:4]   = (s0 != 4'd0) ? s1 : (s1 == 4'd0) ? 4'd5 : s1 - 4'd1;
        dec[11:8]  = !(s0 == 4'd0 && s1 == 4'd0) ? m0 : (m0 == 4'd0) ? 4'd9 : m0 - 4'd1;
        dec[15:12] = !(s0 == 4'd0 && s1 == 4'd0 && m0 == 4'd0) ? m1 : m1 - 4'd1;
        nxt        = dir ? dec : inc;
        terminal   = dir ? (nxt == 16'h0000) : (nxt == 16'h5959);
        at_end     = bus.i_dir ? (value == 16'h0000) : (value == 16'h5959);
        clamp      = {(bus.i_preset[15:12] > 4'd5) ? 4'd5 : bus.i_preset[15:12],
                      (bus.i_preset[11:8]  > 4'd9) ? 4'd9 : bus.i_preset[11:8],
                      (bus.i_preset[7:4]   > 4'd5) ? 4'd5 : bus.i_preset[7:4],
                      (bus.i_preset[3:0]   > 4'd9) ? 4'd9 : bus.i_preset[3:0]};
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state  <= IDLE;
            value  <= '0;
            presc  <= '0;
            dir    <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.i_clear) begin
                state <= IDLE;
                value <= '0;
                presc <= '0;
            end else if (bus.i_load && (state == IDLE || state == DONE)) begin
                state <= IDLE;
                value <= clamp;
                presc <= '0;
            end else begin
                case (state)
                    IDLE: if (bus.i_start) begin
                        dir <= bus.i_dir;
                        // starting at the end value of the chosen direction has nothing to count
                        state  <= at_end ? DONE : RUN;
                        done_q <= at_end;
                    end
                    RUN: begin
                        presc <= tick ? '0 : presc + 1'b1;
                        if (tick) value <= nxt;
                        if (tick && terminal) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                            presc  <= '0;
                        end else if (bus.i_stop) state <= PAUSE;
                    end
                    PAUSE: if (bus.i_start) state <= RUN;
                    DONE: presc <= '0;
                endcase
            end
        end
    end
    logic blank3;
    assign blank3     = bus.i_blank_lz && (m1 == 4'd0);
    assign bus.o_dig3 = blank3 ? 4'hA : m1;
    assign bus.o_dig2 = (blank3 && m0 == 4'd0) ? 4'hA : m0;
    assign bus.o_dig1 = s1;
    assign bus.o_dig0 = s0;
    assign bus.o_run  = (state == RUN);
    assign bus.o_done = done_q;
    assign bus.o_tick = tick;
endmodule

// File: tb/tb_timer_bcd_core.sv
// tb_timer_bcd_core: directed scenario checks of the MM:SS BCD timer with TICK_DIV = 4
module tb_timer_bcd_core;
    logic clk = 1'b0, rst = 1'b1;
    int n_cmp = 0, n_err = 0, done_cnt = 0, tick_cnt = 0;
    int d0, t0;
    logic [15:0] digs;
    timer_bcd_core_if bus();
    timer_bcd_core #(.TICK_DIV(4)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));
    assign digs = {bus.o_dig3, bus.o_dig2, bus.o_dig1, bus.o_dig0};
    always #5 clk = ~clk;
    always @(negedge clk) begin
        if (bus.o_done) done_cnt++;
        if (bus.o_tick) tick_cnt++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [15:0] p);
        bus.i_preset = p; bus.i_load = 1'b1; step(1); bus.i_load = 1'b0;
    endtask

    task automatic do_start(input logic d);
        bus.i_dir = d; bus.i_start = 1'b1; step(1); bus.i_start = 1'b0;
    endtask

    task automatic do_clear();
        bus.i_clear = 1'b1; step(1); bus.i_clear = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; step(2); rst = 1'b0;
        n_cmp++; if (digs !== 16'h0000) begin n_err++; $display("FAIL reset_digs got %h want 0000", digs); end
        n_cmp++; if (bus.o_run !== 1'b0) begin n_err++; $display("FAIL reset_run got %b want 0", bus.o_run); end
        n_cmp++; if (bus.o_done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", bus.o_done); end
        n_cmp++; if (bus.o_tick !== 1'b0) begin n_err++; $display("FAIL reset_tick got %b want 0", bus.o_tick); end
        bus.i_blank_lz = 1'b1; #1;
        n_cmp++; if (digs !== 16'hAA00) begin n_err++; $display("FAIL reset_blank got %h want AA00", digs); end
        bus.i_blank_lz = 1'b0; #1;
    endtask

    task automatic test_carry();
        do_load(16'h0959);
        do_start(1'b0);
        n_cmp++; if (bus.o_run !== 1'b1) begin n_err++; $display("FAIL carry_run got %b want 1", bus.o_run); end
        step(2);
        n_cmp++; if (bus.o_tick !== 1'b0) begin n_err++; $display("FAIL carry_early_tick got %b want 0", bus.o_tick); end
        step(1);
        n_cmp++; if (bus.o_tick !== 1'b1) begin n_err++; $display("FAIL carry_tick got %b want 1", bus.o_tick); end
        n_cmp++; if (digs !== 16'h0959) begin n_err++; $display("FAIL carry_pre got %h want 0959", digs); end
        step(1);
        n_cmp++; if (digs !== 16'h1000) begin n_err++; $display("FAIL carry_chain got %h want 1000", digs); end
        n_cmp++; if (bus.o_tick !== 1'b0) begin n_err++; $display("FAIL carry_tick_off got %b want 0", bus.o_tick); end
        do_clear();
    endtask

    task automatic test_down_done();
        do_load(16'h0002);
        d0 = done_cnt;
        do_start(1'b1);
        step(4);
        n_cmp++; if (digs !== 16'h0001) begin n_err++; $display("FAIL down_first got %h want 0001", digs); end
        n_cmp++; if (bus.o_done !== 1'b0) begin n_err++; $display("FAIL down_early_done got %b want 0", bus.o_done); end
        step(4);
        n_cmp++; if (digs !== 16'h0000) begin n_err++; $display("FAIL down_zero got %h want 0000", digs); end
        n_cmp++; if (bus.o_done !== 1'b1) begin n_err++; $display("FAIL down_done got %b want 1", bus.o_done); end
        n_cmp++; if (bus.o_run !== 1'b0) begin n_err++; $display("FAIL down_run got %b want 0", bus.o_run); end
        step(1);
        n_cmp++; if (bus.o_done !== 1'b0) begin n_err++; $display("FAIL down_done_pulse got %b want 0", bus.o_done); end
        do_start(1'b0);
        step(6);
        n_cmp++; if (digs !== 16'h0000 || bus.o_run !== 1'b0) begin n_err++; $display("FAIL done_start_ignored got %h run %b want 0000 run 0", digs, bus.o_run); end
        n_cmp++; if (done_cnt - d0 !== 1) begin n_err++; $display("FAIL down_done_count got %0d want 1", done_cnt - d0); end
        do_clear();
    endtask

    task automatic test_pause();
        do_start(1'b0);
        step(1);
        bus.i_stop = 1'b1; step(1); bus.i_stop = 1'b0;
        n_cmp++; if (bus.o_run !== 1'b0) begin n_err++; $display("FAIL pause_run got %b want 0", bus.o_run); end
        t0 = tick_cnt;
        step(10);
        n_cmp++; if (tick_cnt !== t0) begin n_err++; $display("FAIL pause_ticks got %0d want %0d", tick_cnt, t0); end
        do_start(1'b0);
        n_cmp++; if (bus.o_tick !== 1'b0 || bus.o_run !== 1'b1) begin n_err++; $display("FAIL resume_state tick %b run %b want 0 1", bus.o_tick, bus.o_run); end
        step(1);
        n_cmp++; if (bus.o_tick !== 1'b1) begin n_err++; $display("FAIL resume_tick got %b want 1", bus.o_tick); end
        step(1);
        n_cmp++; if (digs !== 16'h0001) begin n_err++; $display("FAIL resume_value got %h want 0001", digs); end
        do_clear();
    endtask

    task automatic test_clamp_top();
        do_load(16'hF7A3);
        n_cmp++; if (digs !== 16'h5753) begin n_err++; $display("FAIL clamp got %h want 5753", digs); end
        do_load(16'h5958);
        do_start(1'b0);
        step(3);
        n_cmp++; if (bus.o_tick !== 1'b1 || digs !== 16'h5958) begin n_err++; $display("FAIL top_tick tick %b digs %h want 1 5958", bus.o_tick, digs); end
        step(1);
        n_cmp++; if (digs !== 16'h5959) begin n_err++; $display("FAIL top_value got %h want 5959", digs); end
        n_cmp++; if (bus.o_done !== 1'b1 || bus.o_run !== 1'b0) begin n_err++; $display("FAIL top_done done %b run %b want 1 0", bus.o_done, bus.o_run); end
        step(8);
        n_cmp++; if (digs !== 16'h5959 || bus.o_done !== 1'b0) begin n_err++; $display("FAIL top_hold digs %h done %b want 5959 0", digs, bus.o_done); end
        do_clear();
    endtask

    task automatic test_blank();
        bus.i_blank_lz = 1'b1;
        do_load(16'h0105);
        n_cmp++; if (digs !== 16'hA105) begin n_err++; $display("FAIL blank_tens got %h want A105", digs); end
        do_load(16'h1005);
        n_cmp++; if (digs !== 16'h1005) begin n_err++; $display("FAIL blank_none got %h want 1005", digs); end
        do_load(16'h0005);
        n_cmp++; if (digs !== 16'hAA05) begin n_err++; $display("FAIL blank_both got %h want AA05", digs); end
        bus.i_blank_lz = 1'b0;
        do_clear();
    endtask

    task automatic test_simultaneous();
        do_load(16'h0100);
        do_start(1'b0);
        step(2);
        d0 = done_cnt;
        bus.i_clear = 1'b1; bus.i_start = 1'b1; step(1); bus.i_clear = 1'b0; bus.i_start = 1'b0;
        n_cmp++; if (digs !== 16'h0000 || bus.o_run !== 1'b0) begin n_err++; $display("FAIL clear_start digs %h run %b want 0000 0", digs, bus.o_run); end
        step(6);
        n_cmp++; if (done_cnt !== d0) begin n_err++; $display("FAIL clear_no_done got %0d want %0d", done_cnt, d0); end
        do_load(16'h0030);
        do_start(1'b0);
        do_load(16'h1234);
        n_cmp++; if (digs !== 16'h0030 || bus.o_run !== 1'b1) begin n_err++; $display("FAIL load_in_run digs %h run %b want 0030 1", digs, bus.o_run); end
        do_clear();
        t0 = tick_cnt; d0 = done_cnt;
        do_start(1'b1);
        n_cmp++; if (bus.o_done !== 1'b1 || bus.o_run !== 1'b0) begin n_err++; $display("FAIL down_zero_start done %b run %b want 1 0", bus.o_done, bus.o_run); end
        step(6);
        n_cmp++; if (tick_cnt !== t0 || done_cnt - d0 !== 1) begin n_err++; $display("FAIL down_zero_counts ticks %0d dones %0d want 0 1", tick_cnt - t0, done_cnt - d0); end
    endtask

    initial begin
        bus.i_start = 1'b0; bus.i_stop = 1'b0; bus.i_clear = 1'b0; bus.i_load = 1'b0;
        bus.i_dir = 1'b0; bus.i_blank_lz = 1'b0; bus.i_preset = 16'h0000;
        test_reset();
        test_carry();
        test_down_done();
        test_pause();
        test_clamp_top();
        test_blank();
        test_simultaneous();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
